// File: rtl/serial_byte_subtractor.sv
// serial_byte_subtractor
// Computes diff = a - b one byte per clock, least-significant byte first,
// with one 8-bit subtract slice reused across all bytes. A registered borrow
// links each byte to the next. Operands enter through a valid/ready handshake
// in IDLE. The result is held under valid/ready in DONE until it is taken.
module serial_byte_subtractor #(
    parameter int NBYTES = 4,
    parameter int BW     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BW*NBYTES-1:0] a,
    input  logic [BW*NBYTES-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BW*NBYTES-1:0] diff,
    output logic                 bout,
    output logic                 ovf,
    output logic                 busy
);

    localparam int W    = BW * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    diff_reg;
    logic [W-1:0]    diff_next;
    logic [IDXW-1:0] idx_reg;
    logic            borrow_reg;
    logic            bout_reg;
    logic            ovf_reg;
    logic            out_valid_reg;

    logic [BW-1:0]   a_byte [NBYTES];
    logic [BW-1:0]   b_byte [NBYTES];
    logic [BW-1:0]   a_sel;
    logic [BW-1:0]   b_sel;
    logic [BW:0]     sub_full;
    logic [BW-1:0]   sub_d;
    logic            sub_br;
    logic            ovf_next;

    // Split the latched operands into byte lanes, and build the next diff
    // word by replacing only the lane addressed by the byte index.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign a_byte[gi] = a_reg[gi*BW +: BW];
            assign b_byte[gi] = b_reg[gi*BW +: BW];
            assign diff_next[gi*BW +: BW] =
                (idx_reg == IDXW'(gi)) ? sub_d : diff_reg[gi*BW +: BW];
        end
    endgenerate

    // Shared byte slice: 9-bit subtract, bit BW is the borrow out of this byte.
    assign a_sel    = a_byte[idx_reg];
    assign b_sel    = b_byte[idx_reg];
    assign sub_full = {1'b0, a_sel} - {1'b0, b_sel} - {{BW{1'b0}}, borrow_reg};
    assign sub_d    = sub_full[BW-1:0];
    assign sub_br   = sub_full[BW];

    // Signed overflow: operand signs differ and the result sign differs from a.
    // sub_d is the top byte only when the last index is being processed.
    assign ovf_next = (a_reg[W-1] ^ b_reg[W-1]) & (a_reg[W-1] ^ sub_d[BW-1]);

    // Control FSM plus datapath registers: accept, one byte per CALC edge, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            diff_reg      <= '0;
            idx_reg       <= '0;
            borrow_reg    <= 1'b0;
            bout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        idx_reg    <= '0;
                        borrow_reg <= 1'b0;
                        diff_reg   <= '0;
                        state_reg  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    diff_reg   <= diff_next;
                    borrow_reg <= sub_br;
                    idx_reg    <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        bout_reg      <= sub_br;
                        ovf_reg       <= ovf_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign busy      = (state_reg == ST_CALC);
    assign out_valid = out_valid_reg;
    assign diff      = diff_reg;
    assign bout      = bout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_byte_subtractor.sv
// Testbench for serial_byte_subtractor: directed cases, randomized operands
// against an arithmetic reference, stall, mid-operation reset and streaming.
module tb_serial_byte_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        busy;

    int vectors;
    int miscompares;

    serial_byte_subtractor #(.NBYTES(4), .BW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {bout, ovf, diff} from plain unsigned and signed arithmetic.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [32:0] wide;
        longint      sr;
        logic        o;
        wide = {1'b0, x} - {1'b0, y};
        sr   = longint'($signed(x)) - longint'($signed(y));
        o    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {wide[32], o, wide[31:0]};
    endfunction

    // Drives one operation with out_ready high; returns the result and the
    // number of edges from accept to out_valid. Called at #1 after an edge.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] d, output logic bo, output logic ov,
                         output int lat, output logic busy1);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy1 = busy;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d  = diff;
        bo = bout;
        ov = ovf;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (diff !== 32'h0 || bout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: diff=%h bout=%b ovf=%b out_valid=%b busy=%b in_ready=%b required 0/0/0/0/0/1",
                     diff, bout, ovf, out_valid, busy, in_ready);
        end
        $display("reset: diff=%h out_valid=%b in_ready=%b", diff, out_valid, in_ready);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic [31:0] d;
        logic [33:0] e;
        logic        bo, ov, bz;
        int          lat;
        ta[0] = 32'h12345678; tb[0] = 32'h02040608;
        ta[1] = 32'h00000000; tb[1] = 32'h00000001;
        ta[2] = 32'h80000000; tb[2] = 32'h00000001;
        ta[3] = 32'h7FFFFFFF; tb[3] = 32'hFFFFFFFF;
        ta[4] = 32'hA5A5A5A5; tb[4] = 32'hA5A5A5A5;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], d, bo, ov, lat, bz);
            e = model(ta[i], tb[i]);
            vectors++;
            if (d !== e[31:0] || bo !== e[33] || ov !== e[32]) begin
                miscompares++;
                $display("FAIL directed%0d: a=%h b=%h got diff=%h bout=%b ovf=%b required diff=%h bout=%b ovf=%b",
                         i, ta[i], tb[i], d, bo, ov, e[31:0], e[33], e[32]);
            end
            vectors++;
            if (lat != 4 || bz !== 1'b1) begin
                miscompares++;
                $display("FAIL directed%0d_latency: got %0d edges busy=%b required 4 edges busy=1", i, lat, bz);
            end
            $display("directed%0d: a=%h b=%h diff=%h bout=%b ovf=%b latency=%0d", i, ta[i], tb[i], d, bo, ov, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] av, bv, d;
        logic [33:0] e;
        logic        bo, ov, bz;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            av = $urandom;
            bv = ($urandom_range(0, 3) == 0) ? av : 32'($urandom);
            do_op(av, bv, d, bo, ov, lat, bz);
            e = model(av, bv);
            vectors++;
            if (d !== e[31:0] || bo !== e[33] || ov !== e[32] || lat != 4) begin
                miscompares++;
                $display("FAIL random%0d: a=%h b=%h got diff=%h bout=%b ovf=%b lat=%0d required diff=%h bout=%b ovf=%b lat=4",
                         i, av, bv, d, bo, ov, lat, e[31:0], e[33], e[32]);
            end
            $display("random%0d: a=%h b=%h diff=%h bout=%b ovf=%b", i, av, bv, d, bo, ov);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [31:0] a1, b1, a2, b2;
        logic [33:0] e1, e2;
        int          n;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom;
        e1 = model(a1, b1);
        e2 = model(a2, b2);
        out_ready = 1'b0;
        a = a1; b = b1; in_valid = 1'b1;
        @(posedge clk); #1;
        // Producer immediately presents the next operands and keeps in_valid high.
        a = a2; b = b2;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL stall_latency: got %0d edges required 4", n);
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== e1[31:0] ||
                bout !== e1[33] || ovf !== e1[32]) begin
                miscompares++;
                $display("FAIL stall_hold%0d: out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b required 1/0/%h/%b/%b",
                         i, out_valid, in_ready, diff, bout, ovf, e1[31:0], e1[33], e1[32]);
            end
            $display("stall%0d: out_valid=%b diff=%h", i, out_valid, diff);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_accept: busy=%b required 1", busy);
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n != 4 || diff !== e2[31:0] || bout !== e2[33] || ovf !== e2[32]) begin
            miscompares++;
            $display("FAIL stall_next: lat=%0d diff=%h bout=%b ovf=%b required lat=4 diff=%h bout=%b ovf=%b",
                     n, diff, bout, ovf, e2[31:0], e2[33], e2[32]);
        end
        $display("stall_next: a=%h b=%h diff=%h", a2, b2, diff);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        bo, ov, bz, seen;
        int          lat;
        a = 32'h0; b = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (diff !== 32'h0000FFFF || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midcalc_partial: diff=%h busy=%b required 0000ffff/1", diff, busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (diff !== 32'h0 || bout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midcalc_reset: diff=%h bout=%b ovf=%b out_valid=%b busy=%b in_ready=%b required 0/0/0/0/0/1",
                     diff, bout, ovf, out_valid, busy, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midcalc_noresult: activity after abort=%b required 0", seen);
        end
        do_op(32'd5, 32'd3, d, bo, ov, lat, bz);
        vectors++;
        if (d !== 32'd2 || bo !== 1'b0 || ov !== 1'b0 || lat != 4) begin
            miscompares++;
            $display("FAIL after_reset_op: diff=%h bout=%b ovf=%b lat=%0d required 00000002/0/0/4", d, bo, ov, lat);
        end
        $display("midcalc_reset: next op 5-3 diff=%h bout=%b", d, bo);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa [$];
        logic [31:0] qb [$];
        int          acc_cyc [$];
        logic [33:0] e;
        int          idx, res, cyc;
        logic        acc;
        idx = 0; res = 0; cyc = 0;
        for (int i = 0; i < 5; i++) begin
            qa.push_back($urandom);
            qb.push_back($urandom);
        end
        out_ready = 1'b1;
        a = qa[0]; b = qb[0]; in_valid = 1'b1;
        while (res < 5 && cyc < 100) begin
            acc = in_ready && in_valid;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                acc_cyc.push_back(cyc);
                idx++;
                if (idx < 5) begin
                    a = qa[idx];
                    b = qb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                e = model(qa[res], qb[res]);
                vectors++;
                if (diff !== e[31:0] || bout !== e[33] || ovf !== e[32]) begin
                    miscompares++;
                    $display("FAIL b2b_result%0d: diff=%h bout=%b ovf=%b required diff=%h bout=%b ovf=%b",
                             res, diff, bout, ovf, e[31:0], e[33], e[32]);
                end
                $display("b2b%0d: a=%h b=%h diff=%h bout=%b ovf=%b", res, qa[res], qb[res], diff, bout, ovf);
                res++;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (res != 5 || acc_cyc.size() != 5) begin
            miscompares++;
            $display("FAIL b2b_count: results=%0d accepts=%0d required 5/5", res, acc_cyc.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            vectors++;
            if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
                miscompares++;
                $display("FAIL b2b_spacing%0d: got %0d cycles required 6", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
